// File: rtl/accum_window.sv
// accum_window: sums win_len unsigned samples per window, clamping at the
// maximum SUM_W-bit value, and holds the result until downstream accepts it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; ready never depends combinationally on the same-side valid
// or on the other port. in_ready is low only while a result is held, so a
// result accept and the next window's first sample never share a cycle.
module accum_window #(
  parameter int IN_W  = 4,
  parameter int SUM_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [LEN_W-1:0] win_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  logic             in_hs;
  logic [SUM_W:0]   sum_wide;
  logic [LEN_W-1:0] cnt_inc;
  logic [LEN_W-1:0] len_new;
  logic [SUM_W-1:0] data_ext;

  // Next-state and datapath: load on the first sample, accumulate with clamp,
  // and snapshot the result into the output registers when entering HOLD.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;

    in_hs    = in_valid && in_ready_q;
    data_ext = {{(SUM_W-IN_W){1'b0}}, in_data};
    sum_wide = {1'b0, acc_q} + {1'b0, data_ext};
    cnt_inc  = cnt_q + LEN_ONE;
    len_new  = (win_len == '0) ? LEN_ONE : win_len;

    case (state_q)
      IDLE: begin
        if (in_hs) begin
          len_d = len_new;
          acc_d = data_ext;
          cnt_d = LEN_ONE;
          ovf_d = 1'b0;
          if (len_new == LEN_ONE) begin
            state_d   = HOLD;
            out_sum_d = data_ext;
            out_ovf_d = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_hs) begin
          if (sum_wide[SUM_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_wide[SUM_W-1:0];
          end
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d   = HOLD;
            out_sum_d = acc_d;
            out_ovf_d = ovf_d;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d != HOLD);
  end

  // State and output registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= LEN_ONE;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_accum_window.sv
// Bench for accum_window: one default build (SUM_W=8) and one narrow build
// (SUM_W=6) share all stimulus; each has its own expected-result queue.
module tb_accum_window;

  localparam int IN_W  = 4;
  localparam int SUM_W = 8;
  localparam int SUM6  = 6;
  localparam int LEN_W = 4;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [IN_W-1:0]  in_data = '0;
  logic [LEN_W-1:0] win_len = '0;

  logic             in_ready, out_valid, out_ovf, busy;
  logic [SUM_W-1:0] out_sum;
  logic [1:0]       state_dbg;

  logic             in_ready_6, out_valid_6, out_ovf_6, busy_6;
  logic [SUM6-1:0]  out_sum_6;
  logic [1:0]       state_dbg_6;

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  accum_window #(.IN_W(IN_W), .SUM_W(SUM_W), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .win_len(win_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .busy(busy), .state_dbg(state_dbg)
  );

  accum_window #(.IN_W(IN_W), .SUM_W(SUM6), .LEN_W(LEN_W)) u_dut6 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready_6),
    .in_data(in_data), .win_len(win_len), .out_valid(out_valid_6),
    .out_ready(out_ready), .out_sum(out_sum_6), .out_ovf(out_ovf_6),
    .busy(busy_6), .state_dbg(state_dbg_6)
  );

  // ---------------- scoreboard ----------------
  int vecs = 0;
  int errs = 0;
  logic [SUM_W:0] exp_q[$];
  logic [SUM6:0]  exp6_q[$];

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_win(input int s8, input int o8, input int s6, input int o6);
    exp_q.push_back({1'(o8), 8'(s8)});
    exp6_q.push_back({1'(o6), 6'(s6)});
  endtask

  // Monitor: while a result is presented it must match the queue head and
  // stay stable; it is popped on the cycle it is accepted.
  always @(negedge clk) begin
    if (rst_b) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out8", 1, 0);
        end else begin
          check("out_sum8", int'(out_sum), int'(exp_q[0][SUM_W-1:0]));
          check("out_ovf8", int'(out_ovf), int'(exp_q[0][SUM_W]));
          check("hold_in_ready8", int'(in_ready), 0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (out_valid_6) begin
        if (exp6_q.size() == 0) begin
          check("unexpected_out6", 1, 0);
        end else begin
          check("out_sum6", int'(out_sum_6), int'(exp6_q[0][SUM6-1:0]));
          check("out_ovf6", int'(out_ovf_6), int'(exp6_q[0][SUM6]));
          if (out_ready) void'(exp6_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one sample; returns just after the edge on which it was taken.
  task automatic drive(input int d, input int wl);
    int budget;
    budget = 0;
    in_valid = 1'b1;
    in_data  = 4'(d);
    win_len  = 4'(wl);
    while (!in_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) check("drive_wait_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_sum"},   int'(out_sum), 0);
    check({tag, "_out_ovf"},   int'(out_ovf), 0);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_in_ready"},  int'(in_ready), 1);
    check({tag, "_state"},     int'(state_dbg), 0);
    check({tag, "_out_sum6"},  int'(out_sum_6), 0);
    check({tag, "_out_ovf6"},  int'(out_ovf_6), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  initial begin
    int t1, t2;

    // Reset state
    idle(2);
    check_reset_outputs("reset");
    rst_b = 1'b1;
    idle(1);

    // Basic window: 1+2+3
    expect_win(6, 0, 6, 0);
    drive(1, 3); drive(2, 3); drive(3, 3);
    check("basic_latency_valid", int'(out_valid), 1);
    check("basic_busy_hold", int'(busy), 1);
    idle(1);
    check("basic_valid_one_cycle", int'(out_valid), 0);
    check("basic_sum_retained", int'(out_sum), 6);
    check("basic_in_ready_idle", int'(in_ready), 1);
    check("basic_busy_idle", int'(busy), 0);

    // Single-sample windows: win_len 0 acts as 1; period of 2 cycles
    expect_win(9, 0, 9, 0);
    expect_win(5, 0, 5, 0);
    drive(9, 0);
    t1 = cycle_cnt;
    check("single_len0_valid", int'(out_valid), 1);
    drive(5, 1);
    t2 = cycle_cnt;
    check("single_len1_valid", int'(out_valid), 1);
    check("single_period", t2 - t1, 2);
    idle(1);

    // Clamp: 15 x 15 = 225 fits 8 bits; 6-bit build clamps to 63
    expect_win(225, 0, 63, 1);
    for (int i = 0; i < 15; i++) drive(15, 15);
    idle(1);
    // 5 x 15 = 75
    expect_win(75, 0, 63, 1);
    for (int i = 0; i < 5; i++) drive(15, 5);
    idle(1);

    // Backpressure: 7+8 held for 5 cycles, in_valid offered but not taken
    expect_win(15, 0, 15, 0);
    drive(7, 2);
    out_ready = 1'b0;
    drive(8, 2);
    in_valid = 1'b1;
    in_data  = 4'hA;
    win_len  = 4'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_sum", int'(out_sum), 15);
      idle(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(1);
    check("bp_released_valid", int'(out_valid), 0);
    check("bp_pulse_not_taken", int'(busy), 0);

    // Gapped input 1,0,0,1,1,0,1; later win_len changes are ignored
    expect_win(14, 0, 14, 0);
    drive(2, 4); idle(2); drive(3, 1); drive(4, 0); idle(1); drive(5, 7);
    check("gap_valid", int'(out_valid), 1);
    idle(1);

    // Mid-window reset after 2 of 4 samples, then a clean window of ones
    drive(1, 4); drive(1, 4);
    #2 rst_b = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_b = 1'b1;
    idle(1);
    expect_win(4, 0, 4, 0);
    for (int i = 0; i < 4; i++) drive(1, 4);
    check("post_reset_valid", int'(out_valid), 1);
    idle(4);

    check("queue_drained8", exp_q.size(), 0);
    check("queue_drained6", exp6_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
